// File: rtl/pixel_contrast_stretch.sv
// pixel_contrast_stretch
// Captures one 28x28 frame from the down-sampler while tracking its min/max.
// It then replays the frame with each pixel stretched to the full 0..2^DW-1 range.
// Output cadence is fixed: one pixel every 2*DW+2 cycles.
// That cadence covers the RAM read, the operand load and a 2*DW-step restoring divide.
//
// state   | meaning
// IDLE    | waiting for a frame-valid rising edge
// FILL    | writing pixels into the buffer, tracking min/max
// STREAM  | reading back, scaling, emitting one pixel per slot

module pixel_contrast_stretch #(
  parameter int NPIX = 784,
  parameter int DW   = 8
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          iFVAL,
  input  logic          iDVAL,
  input  logic [DW-1:0] iDATA,
  output logic          oDVAL,
  output logic [DW-1:0] oDATA,
  output logic          oBUSY,
  output logic          oFRAME_DONE,
  output logic          oERR
);

  localparam int NUMW = 2 * DW;
  localparam int AW   = $clog2(NPIX + 1);
  localparam int PHW  = $clog2(NUMW + 2);

  localparam logic [AW-1:0]  LAST_IDX = AW'(NPIX - 1);
  localparam logic [AW-1:0]  END_IDX  = AW'(NPIX);
  localparam logic [PHW-1:0] PH_LOAD  = PHW'(1);
  localparam logic [PHW-1:0] PH_LAST  = PHW'(NUMW + 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM} state_t;

  state_t          state_q, state_d;
  logic            fval_q;
  logic [AW-1:0]   idx_q;
  logic [PHW-1:0]  ph_q;
  logic [DW-1:0]   min_q, max_q, range_q;
  logic [DW-1:0]   rem_q;
  logic [NUMW-1:0] quo_q;
  logic [DW-1:0]   rd_q;
  logic [DW-1:0]   mem [NPIX];

  logic            fval_rise;
  logic            mem_we;
  logic            last_wr;
  logic            stream_done;
  logic [DW-1:0]   min_upd, max_upd;
  logic [DW-1:0]   pdiff;
  logic [NUMW-1:0] num;
  logic [DW:0]     trial;
  logic            ge;
  logic [DW-1:0]   rem_nxt;
  logic [NUMW-1:0] quo_nxt;
  logic [DW-1:0]   quo_sat;

  // Frame-start edge, end-of-fill and end-of-stream conditions, extreme tracking.
  always_comb begin
    fval_rise   = iFVAL & ~fval_q;
    last_wr     = (state_q == S_FILL) && iDVAL && (idx_q == LAST_IDX);
    stream_done = (state_q == S_STREAM) && (idx_q == END_IDX) && (ph_q == '0);
    min_upd     = (iDATA < min_q) ? iDATA : min_q;
    max_upd     = (iDATA > max_q) ? iDATA : max_q;
  end

  // Operand build (255*d = 256*d - d) and one restoring-divide step.
  // The remainder stays below range, so the subtraction fits in DW bits.
  always_comb begin
    pdiff   = rd_q - min_q;
    num     = {pdiff, {DW{1'b0}}} - {{DW{1'b0}}, pdiff};
    trial   = {rem_q, quo_q[NUMW-1]};
    ge      = (trial >= {1'b0, range_q});
    rem_nxt = ge ? (trial[DW-1:0] - range_q) : trial[DW-1:0];
    quo_nxt = {quo_q[NUMW-2:0], ge};
    quo_sat = (quo_nxt[NUMW-1:DW] != '0) ? {DW{1'b1}} : quo_nxt[DW-1:0];
  end

  // State register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; the final write beats a simultaneous frame-valid drop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (fval_rise) state_d = S_FILL;
      S_FILL: begin
        if (last_wr)     state_d = S_STREAM;
        else if (!iFVAL) state_d = S_IDLE;
      end
      S_STREAM: if (stream_done) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Busy flag and buffer write enable decoded from the current state.
  always_comb begin
    oBUSY  = (state_q != S_IDLE);
    mem_we = (state_q == S_FILL) && iDVAL && (iFVAL || (idx_q == LAST_IDX));
  end

  // Frame buffer: one shared index for writes in FILL and reads in STREAM.
  always_ff @(posedge iCLK) begin
    if (mem_we) mem[idx_q] <= iDATA;
    rd_q <= mem[idx_q];
  end

  // Counters, min/max, divider and registered output strobes.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      fval_q      <= 1'b0;
      idx_q       <= '0;
      ph_q        <= '0;
      min_q       <= {DW{1'b1}};
      max_q       <= '0;
      range_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      oDVAL       <= 1'b0;
      oDATA       <= '0;
      oFRAME_DONE <= 1'b0;
      oERR        <= 1'b0;
    end else begin
      fval_q      <= iFVAL;
      oDVAL       <= 1'b0;
      oFRAME_DONE <= 1'b0;
      oERR        <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (fval_rise) begin
            idx_q <= '0;
            min_q <= {DW{1'b1}};
            max_q <= '0;
          end
        end
        S_FILL: begin
          if (mem_we) begin
            idx_q <= idx_q + 1'b1;
            min_q <= min_upd;
            max_q <= max_upd;
          end
          if (last_wr) begin
            idx_q   <= '0;
            ph_q    <= '0;
            range_q <= max_upd - min_upd;
          end else if (!iFVAL) begin
            oERR <= 1'b1;
          end
        end
        S_STREAM: begin
          if (idx_q != END_IDX) begin
            if (ph_q == PH_LAST) begin
              ph_q        <= '0;
              idx_q       <= idx_q + 1'b1;
              oDVAL       <= 1'b1;
              oDATA       <= (range_q == '0) ? '0 : quo_sat;
              oFRAME_DONE <= (idx_q == LAST_IDX);
            end else begin
              ph_q <= ph_q + 1'b1;
            end
            if (range_q != '0) begin
              if (ph_q == PH_LOAD) begin
                rem_q <= '0;
                quo_q <= num;
              end else if (ph_q > PH_LOAD) begin
                rem_q <= rem_nxt;
                quo_q <= quo_nxt;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_contrast_stretch.sv
// Directed bench for pixel_contrast_stretch: ramp, identity, flat, short,
// ignored extra input during STREAM and reset in the middle of a stream.
module tb_pixel_contrast_stretch;

  localparam int NPIX = 784;
  localparam int DW   = 8;
  localparam int SLOT = 18;

  logic          iCLK = 1'b0;
  logic          iRST_N;
  logic          iFVAL;
  logic          iDVAL;
  logic [DW-1:0] iDATA;
  logic          oDVAL;
  logic [DW-1:0] oDATA;
  logic          oBUSY;
  logic          oFRAME_DONE;
  logic          oERR;

  pixel_contrast_stretch #(.NPIX(NPIX), .DW(DW)) dut (
    .iCLK        (iCLK),
    .iRST_N      (iRST_N),
    .iFVAL       (iFVAL),
    .iDVAL       (iDVAL),
    .iDATA       (iDATA),
    .oDVAL       (oDVAL),
    .oDATA       (oDATA),
    .oBUSY       (oBUSY),
    .oFRAME_DONE (oFRAME_DONE),
    .oERR        (oERR)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  logic [DW-1:0] out_q [$];
  int            out_cyc [$];
  int            fd_cyc [$];
  int            err_cnt = 0;

  always @(negedge iCLK) begin
    if (iRST_N) begin
      if (oDVAL) begin
        out_q.push_back(oDATA);
        out_cyc.push_back(cyc);
      end
      if (oFRAME_DONE) fd_cyc.push_back(cyc);
      if (oERR) err_cnt = err_cnt + 1;
    end
  end

  typedef struct {
    int pin;
    int pout;
  } vec_t;

  vec_t ramp_tab [7];
  vec_t fresh_tab [4];

  logic [DW-1:0] frm [NPIX];
  int            expv [NPIX];
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic int stretch(input int p, input int mn, input int mx);
    if (mx == mn) return 0;
    return ((p - mn) * 255) / (mx - mn);
  endfunction

  task automatic drive_frame(input int n_pix, input bit drop_on_last, output int stream_start);
    stream_start = -1;
    @(posedge iCLK); #1;
    iFVAL = 1'b1;
    iDVAL = 1'b0;
    @(posedge iCLK); #1;
    for (int i = 0; i < n_pix; i++) begin
      iDVAL = 1'b1;
      iDATA = frm[i];
      if (drop_on_last && i == n_pix - 1) iFVAL = 1'b0;
      stream_start = cyc + 1;
      @(posedge iCLK); #1;
    end
    iDVAL = 1'b0;
    iDATA = '0;
    iFVAL = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int fdb);
    for (int t = 0; t < SLOT * NPIX + 200 && fd_cyc.size() == fdb; t++) begin
      @(negedge iCLK); #2;
    end
    check({nm, " frame_done seen"}, (fd_cyc.size() > fdb) ? 1 : 0, 1);
    @(negedge iCLK); #2;
    check({nm, " busy low after done"}, int'(oBUSY), 0);
  endtask

  task automatic check_stream(input string nm, input int start, input int base, input int fdb);
    int nbad, first, ncad, cfirst, fdc;
    check({nm, " pulse count"}, out_q.size() - base, NPIX);
    nbad = 0; first = -1; ncad = 0; cfirst = -1;
    for (int k = 0; k < NPIX; k++) begin
      if (base + k < out_q.size()) begin
        if (int'(out_q[base + k]) != expv[k]) begin
          nbad++;
          if (first < 0) first = k;
        end
        if (out_cyc[base + k] != start + SLOT * (k + 1)) begin
          ncad++;
          if (cfirst < 0) cfirst = k;
        end
      end
    end
    check($sformatf("%s data errors (first px %0d)", nm, first), nbad, 0);
    check($sformatf("%s cadence errors (first px %0d)", nm, cfirst), ncad, 0);
    check({nm, " frame_done count"}, fd_cyc.size() - fdb, 1);
    fdc = (fd_cyc.size() > fdb) ? fd_cyc[fdb] : -1;
    check({nm, " frame_done cycle"}, fdc - start, SLOT * NPIX);
  endtask

  int st, base, fdb, eb, got, k;

  initial begin
    ramp_tab[0]  = '{16, 0};
    ramp_tab[1]  = '{215, 255};
    ramp_tab[2]  = '{115, 126};
    ramp_tab[3]  = '{17, 1};
    ramp_tab[4]  = '{116, 128};
    ramp_tab[5]  = '{200, 235};
    ramp_tab[6]  = '{35, 24};
    fresh_tab[0] = '{50, 0};
    fresh_tab[1] = '{149, 255};
    fresh_tab[2] = '{99, 126};
    fresh_tab[3] = '{100, 128};

    iRST_N = 1'b0;
    iFVAL  = 1'b0;
    iDVAL  = 1'b0;
    iDATA  = '0;
    #2;
    check("reset oDVAL", int'(oDVAL), 0);
    check("reset oDATA", int'(oDATA), 0);
    check("reset oBUSY", int'(oBUSY), 0);
    check("reset oFRAME_DONE", int'(oFRAME_DONE), 0);
    check("reset oERR", int'(oERR), 0);
    repeat (3) @(negedge iCLK);
    iRST_N = 1'b1;

    // Ramp frame: min 16, max 215.
    for (int i = 0; i < NPIX; i++) begin
      frm[i]  = DW'(16 + (i % 200));
      expv[i] = stretch(16 + (i % 200), 16, 215);
    end
    base = out_q.size(); fdb = fd_cyc.size(); eb = err_cnt;
    drive_frame(NPIX, 1'b0, st);
    wait_done("ramp", fdb);
    check_stream("ramp", st, base, fdb);
    for (int v = 0; v < 7; v++) begin
      k = ramp_tab[v].pin - 16;
      got = (base + k < out_q.size()) ? int'(out_q[base + k]) : -1;
      check($sformatf("ramp in %0d", ramp_tab[v].pin), got, ramp_tab[v].pout);
    end
    check("ramp no err", err_cnt - eb, 0);

    // Short frame: frame-valid drops after 500 pixels.
    base = out_q.size(); fdb = fd_cyc.size(); eb = err_cnt;
    drive_frame(500, 1'b0, st);
    repeat (6) @(negedge iCLK);
    #2;
    check("short err pulses", err_cnt - eb, 1);
    check("short no output", out_q.size() - base, 0);
    check("short no done", fd_cyc.size() - fdb, 0);
    check("short busy low", int'(oBUSY), 0);

    // Identity frame; frame-valid drops together with the final pixel.
    for (int i = 0; i < NPIX; i++) begin
      frm[i]  = DW'((i * 37 + 11) % 256);
      expv[i] = (i * 37 + 11) % 256;
    end
    base = out_q.size(); fdb = fd_cyc.size(); eb = err_cnt;
    drive_frame(NPIX, 1'b1, st);
    wait_done("identity", fdb);
    check_stream("identity", st, base, fdb);
    check("identity no err", err_cnt - eb, 0);

    // Flat frame with a stray frame start and pixels injected during STREAM.
    for (int i = 0; i < NPIX; i++) begin
      frm[i]  = 8'd100;
      expv[i] = 0;
    end
    base = out_q.size(); fdb = fd_cyc.size(); eb = err_cnt;
    drive_frame(NPIX, 1'b0, st);
    repeat (2000) @(posedge iCLK);
    #1;
    iFVAL = 1'b1;
    for (int i = 0; i < 6; i++) begin
      iDVAL = 1'b1;
      iDATA = (i % 2 == 0) ? 8'd0 : 8'd255;
      @(posedge iCLK); #1;
    end
    iDVAL = 1'b0;
    repeat (4) @(posedge iCLK);
    #1;
    iFVAL = 1'b0;
    wait_done("flat", fdb);
    check_stream("flat", st, base, fdb);
    check("flat no err", err_cnt - eb, 0);

    // Frame after the flat one is captured; reset lands after pixel 300.
    for (int i = 0; i < NPIX; i++) begin
      frm[i]  = DW'((i * 37 + 11) % 256);
      expv[i] = (i * 37 + 11) % 256;
    end
    base = out_q.size(); fdb = fd_cyc.size();
    drive_frame(NPIX, 1'b0, st);
    for (int t = 0; t < SLOT * 320 && out_q.size() < base + 300; t++) begin
      @(negedge iCLK); #2;
    end
    check("midreset 300 pulses reached", out_q.size() - base, 300);
    got = 0;
    for (int i = 0; i < 300 && base + i < out_q.size(); i++)
      if (int'(out_q[base + i]) != expv[i]) got++;
    check("midreset pre-reset data errors", got, 0);
    @(posedge iCLK); #3;
    iRST_N = 1'b0;
    #1;
    check("midreset oDVAL", int'(oDVAL), 0);
    check("midreset oDATA", int'(oDATA), 0);
    check("midreset oBUSY", int'(oBUSY), 0);
    check("midreset oFRAME_DONE", int'(oFRAME_DONE), 0);
    check("midreset oERR", int'(oERR), 0);
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    iRST_N = 1'b1;
    repeat (40) @(posedge iCLK);
    #1;
    check("midreset idle after release", int'(oBUSY), 0);
    check("midreset no further pulses", out_q.size() - base, 300);
    check("midreset no done", fd_cyc.size() - fdb, 0);

    // Fresh frame after reset: min 50, max 149.
    for (int i = 0; i < NPIX; i++) begin
      frm[i]  = DW'(50 + (i % 100));
      expv[i] = stretch(50 + (i % 100), 50, 149);
    end
    base = out_q.size(); fdb = fd_cyc.size(); eb = err_cnt;
    drive_frame(NPIX, 1'b0, st);
    wait_done("fresh", fdb);
    check_stream("fresh", st, base, fdb);
    for (int v = 0; v < 4; v++) begin
      k = fresh_tab[v].pin - 50;
      got = (base + k < out_q.size()) ? int'(out_q[base + k]) : -1;
      check($sformatf("fresh in %0d", fresh_tab[v].pin), got, fresh_tab[v].pout);
    end
    check("fresh no err", err_cnt - eb, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pixel_contrast_stretch.md
Name: pixel_contrast_stretch

Overview:
- Sits between the 28x28 down-sampler output (8-bit pixel + valid) and the frame-store FSM that packs pixels into 256-bit DMEM words.
- Buffers one complete 28x28 frame and tracks its min/max.
- Then streams the frame back out, contrast-stretched to the full 0..255 range, so the NN sees normalised input regardless of exposure.
- Runs entirely in the camera pixel-clock domain.

Parameters:
- NPIX, 784, pixels per frame (28x28); buffer depth; counter wrap point.
- DW, 8, pixel width in/out.

Ports:
- iCLK  in  1  pixel clock (D5M_PIXLCLK domain).
- iRST_N  in  1  asynchronous active-low reset.
- iFVAL  in  1  registered camera frame-valid; rising edge marks frame start.
- iDVAL  in  1  input pixel strobe, one cycle per pixel.
- iDATA  in  DW  input pixel, valid when iDVAL=1.
- oDVAL  out  1  output pixel strobe, one-cycle pulse.
- oDATA  out  DW  stretched pixel, valid when oDVAL=1.
- oBUSY  out  1  high in any state other than IDLE.
- oFRAME_DONE  out  1  one-cycle pulse after the last output pixel.
- oERR  out  1  one-cycle pulse when a frame is aborted (short frame).

Behaviour:
- Reset (async, any state): all outputs 0; state=IDLE; counters 0; min=8'hFF, max=8'h00. Buffer contents are don't-care.
- Internal storage: NPIX x DW single-port RAM (inferred), 10-bit write/read index.
- State machine: IDLE -> FILL -> STREAM -> IDLE.
- IDLE:
  - Wait for iFVAL rising edge (iFVAL=1 with previous-cycle iFVAL=0).
  - On that edge: clear index, min=FF, max=00, go to FILL.
  - iDVAL in IDLE is ignored.
- FILL:
  - Each iDVAL=1: write iDATA at index, index++.
  - min/max update uses iDATA in the same cycle, so a pixel equal to the current extreme is harmless.
  - When the write of pixel NPIX-1 occurs, go to STREAM next cycle. Any further iDVAL in the frame is ignored.
  - If iFVAL falls while index<NPIX: pulse oERR the next cycle and return to IDLE; no output is produced.
  - If iFVAL falls on the same cycle as the final write, the final write wins and the block goes to STREAM.
- STREAM:
  - On entry, latch range = max - min (8-bit, unsigned).
  - For each pixel k = 0..NPIX-1, in order:
    - Read buffer[k] (1 cycle).
    - Form num = (p - min) * 255, 16-bit; p >= min is guaranteed.
    - Divide with a restoring divider, num / range, 16 iterations, quotient floored.
    - Quotient is saturated to 255; it cannot exceed it, but saturate anyway.
  - Fixed cadence: one output per 18 cycles. oDVAL for pixel k rises exactly 18*(k+1) cycles after the cycle STREAM is entered.
  - If range==0 (flat frame): every oDATA=0, same cadence; no division is started.
  - After pixel NPIX-1: assert oFRAME_DONE in the same cycle as its oDVAL, then go to IDLE next cycle.
  - iFVAL edges and iDVAL in STREAM are ignored; the next accepted frame starts at the first iFVAL rising edge seen in IDLE.
- No backpressure: the downstream FSM must accept every oDVAL pulse.
- oDATA holds its last value between pulses; it is 0 after reset.
- oBUSY=1 in FILL and STREAM.

Test Plan:
- Ramp frame: pixel k = 16 + (k mod 200) -> min 16, max 215, range 199.
  - Input 16 -> 0; input 215 -> 255; input 115 -> floor(25245/199) = 126.
  - 784 oDVAL pulses, 18 cycles apart; oFRAME_DONE coincides with pulse 784.
- Identity: frame containing 0 and 255 with arbitrary values between -> oDATA == iDATA for every pixel, in original order.
- Flat frame all 8'd100 -> 784 pulses, all oDATA=0, no oERR.
- Short frame: iFVAL falls after 500 pixels -> oERR pulses once, zero oDVAL, oBUSY returns 0.
  - Next full frame is then processed normally.
- Extra input: second iFVAL rising edge plus iDVAL during STREAM -> ignored; output sequence unchanged; frame after return to IDLE is captured.
- Reset asserted at pixel 300 of STREAM -> outputs 0 immediately (async), state IDLE.
  - After release, a fresh full frame produces correct output with min/max not contaminated by the prior frame.
